// File: rtl/folded_simd_register_pkg.sv
// Shared ALU configuration. It holds the SIMD lane geometry, the temporary SRAM depth
// and the default fold factor of the folded temporary register file.
package TauCfg;

   localparam int TMP_DATA_BW = 8;
   localparam int VSIZE       = 4;
   localparam int SRAM_NWORD  = 16;
   localparam int SIMD_NFOLD  = 4;

endpackage

// File: rtl/folded_simd_register_sram.sv
// Single-port synchronous SRAM model. A read has a latency of one cycle, and the read
// register changes only when a read is issued.
module SRAMOnePort #(
   parameter int BW    = 32,
   parameter int NWORD = 16,
   localparam int ABW  = $clog2(NWORD)
) (
   input  logic           i_clk,
   input  logic           i_ce,
   input  logic           i_we,
   input  logic [ABW-1:0] i_addr,
   input  logic [BW-1:0]  i_wdata,
   output logic [BW-1:0]  o_rdata
);

   logic [BW-1:0] mem_q [NWORD];
   logic [BW-1:0] rdata_q;

   // NOTE: storage arrays get no reset; clearing them would defeat SRAM mapping.
   always_ff @(posedge i_clk) begin
      if (i_ce) begin
         if (i_we) mem_q[i_addr] <= i_wdata;
         else      rdata_q       <= mem_q[i_addr];
      end
   end

   assign o_rdata = rdata_q;

endmodule

// File: rtl/folded_simd_register.sv
// Folded SIMD temporary register file. NFOLD vector beats share one wide single-port SRAM
// row, with a pending-write register, a read bypass and a held read row.
module folded_simd_register #(
   parameter int NFOLD   = TauCfg::SIMD_NFOLD,
   parameter int NWORD   = TauCfg::SRAM_NWORD,
   parameter int TDBW    = TauCfg::TMP_DATA_BW,
   parameter int VSIZE   = TauCfg::VSIZE,
   localparam int FLAT_BW = TDBW * VSIZE,
   localparam int ABW     = $clog2(NWORD),
   localparam int BBW     = $clog2(NFOLD)
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_we,
   input  logic               i_wlast,
   input  logic [ABW-1:0]     i_waddr,
   input  logic [FLAT_BW-1:0] i_wdata,
   output logic               o_wready,
   input  logic               i_re,
   input  logic               i_rlast,
   input  logic [ABW-1:0]     i_raddr,
   output logic               o_rvalid,
   output logic [FLAT_BW-1:0] o_rdata
);

   typedef logic [NFOLD-1:0][FLAT_BW-1:0] row_t;

   logic [BBW-1:0] wbeat_q, rbeat_q, rsel_q;
   row_t           wbuf_q, pend_row_q, byp_row_q, rword_q;
   logic [ABW-1:0] pend_addr_q;
   logic           pend_v_q, pend_v_d, wready_q;
   logic           rvalid_q, rfirst_q, byp_q;

   logic           rd0, wr_close, byp_hit;
   row_t           wrow, cur_row, sram_rdata, sram_wdata;
   logic           sram_ce, sram_we;
   logic [ABW-1:0] sram_addr;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rd0      = i_re && (rbeat_q == '0);
      wr_close = i_we && ((wbeat_q == BBW'(NFOLD - 1)) || i_wlast);
      byp_hit  = rd0 && pend_v_q && (i_raddr == pend_addr_q);

      wrow = '0;
      for (int j = 0; j < NFOLD; j++) begin
         if (j < int'(wbeat_q))       wrow[j] = wbuf_q[j];
         else if (j == int'(wbeat_q)) wrow[j] = i_wdata;
      end

      // Read beat 0 owns the port; the pending write then beats a fresh closing write.
      sram_ce    = rd0 || pend_v_q || wr_close;
      sram_we    = !rd0 && (pend_v_q || wr_close);
      sram_addr  = rd0 ? i_raddr : (pend_v_q ? pend_addr_q : i_waddr);
      sram_wdata = pend_v_q ? pend_row_q : wrow;

      pend_v_d = rd0 ? (pend_v_q || wr_close) : 1'b0;
      cur_row  = rfirst_q ? (byp_q ? byp_row_q : sram_rdata) : rword_q;
   end

   SRAMOnePort #(.BW(FLAT_BW * NFOLD), .NWORD(NWORD)) u_sram (
      .i_clk   (i_clk),
      .i_ce    (sram_ce),
      .i_we    (sram_we),
      .i_addr  (sram_addr),
      .i_wdata (sram_wdata),
      .o_rdata (sram_rdata)
   );

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wbeat_q     <= '0;
         rbeat_q     <= '0;
         wbuf_q      <= '0;
         pend_v_q    <= 1'b0;
         pend_addr_q <= '0;
         pend_row_q  <= '0;
         wready_q    <= 1'b1;
         rvalid_q    <= 1'b0;
         rfirst_q    <= 1'b0;
         rsel_q      <= '0;
         byp_q       <= 1'b0;
         byp_row_q   <= '0;
         rword_q     <= '0;
      end else begin
         if (i_we) begin
            if (wr_close) begin
               wbeat_q <= '0;
            end else begin
               wbuf_q[wbeat_q] <= i_wdata;
               wbeat_q         <= wbeat_q + 1'b1;
            end
         end
         if (i_re) begin
            rbeat_q <= ((rbeat_q == BBW'(NFOLD - 1)) || i_rlast) ? '0 : rbeat_q + 1'b1;
         end

         pend_v_q <= pend_v_d;
         wready_q <= !pend_v_d;
         if (wr_close && rd0) begin
            pend_addr_q <= i_waddr;
            pend_row_q  <= wrow;
         end

         rvalid_q <= i_re;
         rsel_q   <= rbeat_q;
         rfirst_q <= rd0;
         byp_q    <= byp_hit;
         if (byp_hit)  byp_row_q <= pend_row_q;
         // Later beats read this copy, so writes that land mid-group cannot reach them.
         if (rfirst_q) rword_q   <= cur_row;
      end
   end

   assign o_wready = wready_q;
   assign o_rvalid = rvalid_q;
   assign o_rdata  = rvalid_q ? cur_row[rsel_q] : '0;

   a_no_close_while_pending : assert property (
      @(posedge i_clk) disable iff (!i_rst_n) !(wr_close && pend_v_q)
   ) else $error("closing write beat while a write is already pending");

endmodule

// File: tb/tb_folded_simd_register.sv
// Self-checking bench for folded_simd_register with NFOLD=4, 32-bit beats and 16 rows.
// A row-level memory model predicts every output cycle.
module tb_folded_simd_register;

   localparam int NF = 4;
   localparam int NW = 16;
   localparam int FB = 32;

   logic          clk, rst_n;
   logic          we, wlast, re, rlast;
   logic [3:0]    waddr, raddr;
   logic [FB-1:0] wdata, rdata;
   logic          wready, rvalid;

   folded_simd_register #(.NFOLD(NF), .NWORD(NW), .TDBW(8), .VSIZE(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_we    (we),
      .i_wlast (wlast),
      .i_waddr (waddr),
      .i_wdata (wdata),
      .o_wready(wready),
      .i_re    (re),
      .i_rlast (rlast),
      .i_raddr (raddr),
      .o_rvalid(rvalid),
      .o_rdata (rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [FB-1:0] got, input logic [FB-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
   endtask

   // Reference model: whole rows per address, a pending row, and the current group state.
   bit [FB-1:0] mem [NW][NF];
   bit [FB-1:0] wbuf [NF];
   bit [FB-1:0] rrow [NF];
   bit [FB-1:0] prow [NF];
   bit          pend;
   int          paddr, wcnt, rcnt;
   bit          exp_valid, exp_wready;
   bit [FB-1:0] exp_data;

   task automatic step(input bit we_i, input bit wl_i, input int wa, input bit [FB-1:0] wd,
                       input bit re_i, input bit rl_i, input int ra);
      bit          rd0;
      bit [FB-1:0] row [NF];
      we = we_i; wlast = wl_i; waddr = 4'(wa); wdata = wd;
      re = re_i; rlast = rl_i; raddr = 4'(ra);

      rd0 = re_i && (rcnt == 0);
      if (re_i) begin
         if (rcnt == 0) rrow = (pend && ra == paddr) ? prow : mem[ra];
         exp_valid = 1'b1;
         exp_data  = rrow[rcnt];
         rcnt      = (rcnt == NF - 1 || rl_i) ? 0 : rcnt + 1;
      end else begin
         exp_valid = 1'b0;
         exp_data  = '0;
      end
      if (pend && !rd0) begin
         mem[paddr] = prow;
         pend       = 1'b0;
      end
      if (we_i) begin
         wbuf[wcnt] = wd;
         if (wcnt == NF - 1 || wl_i) begin
            for (int j = 0; j < NF; j++) row[j] = (j <= wcnt) ? wbuf[j] : '0;
            if (rd0) begin
               pend = 1'b1; paddr = wa; prow = row;
            end else begin
               mem[wa] = row;
            end
            wcnt = 0;
         end else begin
            wcnt++;
         end
      end
      exp_wready = !pend;

      @(posedge clk);
      #1;
      check("rvalid", FB'(rvalid), FB'(exp_valid));
      check("rdata", rdata, exp_data);
      check("wready", FB'(wready), FB'(exp_wready));
      @(negedge clk);
   endtask

   task automatic idle();
      step(0, 0, 0, '0, 0, 0, 0);
   endtask

   task automatic write_group(input int a, input int n, input bit [FB-1:0] base);
      for (int i = 0; i < n; i++) step(1, (i == n - 1), a, base + FB'(i), 0, 0, 0);
   endtask

   task automatic read_group(input int a, input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, '0, 1, (i == n - 1), a);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      we = 0; wlast = 0; re = 0; rlast = 0; waddr = '0; raddr = '0; wdata = '0;
      wcnt = 0; rcnt = 0; pend = 1'b0;
      #1;
      check("rst_rvalid", FB'(rvalid), '0);
      check("rst_rdata", rdata, '0);
      check("rst_wready", FB'(wready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   bit [FB-1:0] old0, new0;

   initial begin
      pend = 1'b0; wcnt = 0; rcnt = 0;
      @(negedge clk);
      apply_reset();

      for (int a = 0; a < NW; a++) write_group(a, NF, $urandom);

      // Full group then full read: beats 1..4 come back in order.
      write_group(5, 4, 32'h1);
      idle();
      for (int k = 0; k < NF; k++) begin
         step(0, 0, 0, '0, 1, (k == NF - 1), 5);
         check("t1_data", rdata, FB'(k + 1));
      end
      idle();
      check("t1_valid_drop", FB'(rvalid), '0);

      // Short group closed by wlast: upper slices read back as zero.
      write_group(3, 2, 32'hA0);
      idle();
      for (int k = 0; k < NF; k++) begin
         step(0, 0, 0, '0, 1, 1'b0, 3);
         if (k >= 2) check("t2_zero", rdata, '0);
      end

      // Same-cycle read beat 0 and closing write to addr 7: old row, write pends.
      old0 = mem[7][0];
      for (int i = 0; i < NF - 1; i++) step(1, 0, 7, 32'h700 + FB'(i), 0, 0, 0);
      step(1, 0, 7, 32'h703, 1, 0, 7);
      check("t3_old", rdata, old0);
      check("t3_wready_low", FB'(wready), '0);
      step(0, 0, 0, '0, 1, 0, 7);
      check("t3_wready_high", FB'(wready), 32'd1);
      step(0, 0, 0, '0, 1, 0, 7);
      step(0, 0, 0, '0, 1, 0, 7);
      read_group(7, NF);

      // Conflict on addr 9, then a bypassed one-beat read while still pending.
      for (int i = 0; i < NF - 1; i++) step(1, 0, 9, 32'h900 + FB'(i), 0, 0, 0);
      new0 = 32'h900;
      step(1, 0, 9, 32'h903, 1, 1, 2);
      step(0, 0, 0, '0, 1, 1, 9);
      check("t4_bypass", rdata, new0);
      check("t4_still_pend", FB'(wready), '0);
      idle();
      check("t4_drained", FB'(wready), 32'd1);
      read_group(9, NF);

      // Writes to another row during read beats 1..3 leave the held row intact.
      write_group(4, NF, 32'h400);
      idle();
      step(0, 0, 0, '0, 1, 0, 4);
      for (int k = 1; k < NF; k++) step(1, 0, 6, 32'h600 + FB'(k), 1, 0, 4);
      step(1, 0, 6, 32'h6FF, 0, 0, 0);
      read_group(4, NF);
      read_group(6, NF);

      // Reset mid write group, then reset with a write pending.
      write_group(8, 2, 32'h8000);
      step(1, 0, 8, 32'h8888, 0, 0, 0);
      apply_reset();
      read_group(8, NF);
      old0 = mem[10][0];
      for (int i = 0; i < NF - 1; i++) step(1, 0, 10, 32'hA00 + FB'(i), 0, 0, 0);
      step(1, 0, 10, 32'hA03, 1, 1, 1);
      apply_reset();
      step(0, 0, 0, '0, 1, 0, 10);
      check("t6_old", rdata, old0);
      step(0, 0, 0, '0, 1, 1, 10);

      // Random traffic; a closing write is withheld while one is pending.
      for (int c = 0; c < 1500; c++) begin
         bit          r_we, r_wl, r_re, r_rl;
         int          r_wa, r_ra;
         bit [FB-1:0] r_wd;
         r_we = ($urandom_range(1) == 1);
         r_wl = ($urandom_range(3) == 0);
         r_re = ($urandom_range(1) == 1);
         r_rl = ($urandom_range(3) == 0);
         r_wa = int'($urandom_range(NW - 1));
         r_ra = int'($urandom_range(NW - 1));
         r_wd = $urandom;
         if (r_we && (wcnt == NF - 1 || r_wl) && pend) r_we = 1'b0;
         step(r_we, r_wl, r_wa, r_wd, r_re, r_rl, r_ra);
      end
      idle();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
